boundary_search_ctrl: RTL and testbench

- Connected-domain filter stage. Operates on a 512x512 binary image held in BRAM as 512 rows of 16 x 32-bit words.
- From a given start row it walks downward. For each row it finds the first contiguous pixel segment, where gaps of up to i_MAX_INTERVAL zero pixels are tolerated.
- It writes the row back with every pixel outside that segment cleared.
- It sits between the top-level BRAM word-read controller and the BRAM word-write controller.

---
 rtl/boundary_search_ctrl_pkg.sv | 21 ++
 rtl/boundary_search_ctrl_scan.sv | 66 ++++++
 rtl/boundary_search_ctrl.sv | 149 ++++++++++++++
 tb/tb_boundary_search_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boundary_search_ctrl_pkg.sv
// Shared sizes and FSM encoding for the boundary search controller.
package boundary_search_ctrl_pkg;
    localparam int ROW_W         = 512;
    localparam int WORDS_PER_ROW = 16;
    localparam int WORD_W        = 32;
    localparam int ADDR_W        = 13;
    localparam int ROW_IDX_W     = 9;
    localparam int WORD_IDX_W    = 4;
    localparam int COL_W         = 9;
    localparam int GAP_W         = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        SCAN,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_e;
endpackage

// File: rtl/boundary_search_ctrl_scan.sv
// Per-column segment tracker: finds the first run of set pixels, bridging
// zero gaps of up to max_gap pixels.
module boundary_scan_unit
    import boundary_search_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic             pixel_i,
    input  logic [COL_W-1:0] col_i,
    input  logic [3:0]       max_gap_i,
    output logic [COL_W-1:0] left_o,
    output logic [COL_W-1:0] right_o,
    output logic             found_o,
    output logic             seg_end_o
);
    logic [COL_W-1:0] left_q, left_d, right_q, right_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             found_q, found_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            left_q  <= '0;
            right_q <= '0;
            gap_q   <= '0;
            found_q <= 1'b0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
            gap_q   <= gap_d;
            found_q <= found_d;
        end
    end

    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        gap_d     = gap_q;
        found_d   = found_q;
        seg_end_o = 1'b0;
        if (clr_i) begin
            left_d  = '0;
            right_d = '0;
            gap_d   = '0;
            found_d = 1'b0;
        end else if (valid_i) begin
            if (pixel_i) begin
                if (!found_q) begin
                    left_d  = col_i;
                    found_d = 1'b1;
                end
                right_d = col_i;
                gap_d   = '0;
            end else if (found_q) begin
                gap_d     = gap_q + 5'd1;
                // The zero that pushes the gap past the limit closes the segment.
                seg_end_o = (gap_q + 5'd1) > {1'b0, max_gap_i};
            end
        end
    end

    assign left_o  = left_q;
    assign right_o = right_q;
    assign found_o = found_q;
endmodule

// File: rtl/boundary_search_ctrl.sv
// Walks rows downward from a start row, keeping only the first (gap-tolerant)
// pixel segment of each row and writing the row back; stops at an empty row.
module boundary_search_ctrl
    import boundary_search_ctrl_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_trig,
    output logic                 o_done,
    input  logic [3:0]           i_MAX_INTERVAL,
    input  logic [ROW_IDX_W-1:0] row_num_to_start,
    output logic [ADDR_W-1:0]    u_rd_512b_from_bram_o_rd_from_bram_addr,
    input  logic [WORD_W-1:0]    u_rd_512b_from_bram_i_rd_from_bram_data,
    output logic                 u_rd_512b_from_bram_o_rd_from_bram_trig,
    input  logic                 u_rd_512b_from_bram_i_rd_from_bram_done,
    output logic [ADDR_W-1:0]    u_wr_512b_to_bram_o_wr_to_bram_addr,
    output logic [WORD_W-1:0]    u_wr_512b_to_bram_o_wr_to_bram_data,
    output logic                 u_wr_512b_to_bram_o_wr_to_bram_trig,
    input  logic                 u_wr_512b_to_bram_i_wr_to_bram_done
);
    state_e                state_q, state_d;
    logic [ROW_IDX_W-1:0]  row_q, row_d;
    logic [WORD_IDX_W-1:0] word_q, word_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [3:0]            gap_max_q, gap_max_d;
    logic [ROW_W-1:0]      buf_q;

    logic                  rd_done, wr_done;
    logic                  scan_clr, scan_valid, pix;
    logic [COL_W-1:0]      seg_left, seg_right;
    logic                  seg_found, seg_end;
    logic [WORD_W-1:0]     cur_word, masked_word;
    logic [COL_W-1:0]      wcol;

    assign rd_done = u_rd_512b_from_bram_i_rd_from_bram_done;
    assign wr_done = u_wr_512b_to_bram_i_wr_to_bram_done;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            row_q     <= '0;
            word_q    <= '0;
            col_q     <= '0;
            gap_max_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            word_q    <= word_d;
            col_q     <= col_d;
            gap_max_q <= gap_max_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            buf_q <= '0;
        else if (state_q == RD_WAIT && rd_done)
            buf_q[{word_q, 5'd0} +: WORD_W] <= u_rd_512b_from_bram_i_rd_from_bram_data;
    end

    assign pix        = buf_q[col_q];
    assign scan_valid = (state_q == SCAN);

    boundary_scan_unit u_scan (
        .clk_i     (i_clk),
        .rstn_i    (i_rstn),
        .clr_i     (scan_clr),
        .valid_i   (scan_valid),
        .pixel_i   (pix),
        .col_i     (col_q),
        .max_gap_i (gap_max_q),
        .left_o    (seg_left),
        .right_o   (seg_right),
        .found_o   (seg_found),
        .seg_end_o (seg_end)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        word_d    = word_q;
        col_d     = col_q;
        gap_max_d = gap_max_q;
        scan_clr  = 1'b0;
        unique case (state_q)
            IDLE: if (i_trig) begin
                row_d     = row_num_to_start;
                gap_max_d = i_MAX_INTERVAL;
                word_d    = '0;
                state_d   = RD_REQ;
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: if (rd_done) begin
                if (word_q == 4'd15) begin
                    word_d   = '0;
                    col_d    = '0;
                    scan_clr = 1'b1;
                    state_d  = SCAN;
                end else begin
                    word_d  = word_q + 4'd1;
                    state_d = RD_REQ;
                end
            end
            SCAN: begin
                if (seg_end || col_q == 9'd511) begin
                    // Tracker flag lags one cycle; include the pixel under the cursor.
                    state_d = (seg_found || pix) ? WR_REQ : DONE;
                end else begin
                    col_d = col_q + 9'd1;
                end
            end
            WR_REQ: state_d = WR_WAIT;
            WR_WAIT: if (wr_done) begin
                if (word_q != 4'd15) begin
                    word_d  = word_q + 4'd1;
                    state_d = WR_REQ;
                end else begin
                    word_d = '0;
                    if (row_q == 9'd511) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + 9'd1;
                        state_d = RD_REQ;
                    end
                end
            end
            DONE: if (!i_trig) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cur_word = buf_q[{word_q, 5'd0} +: WORD_W];

    always_comb begin
        masked_word = '0;
        wcol        = '0;
        for (int b = 0; b < WORD_W; b++) begin
            wcol           = {word_q, 5'(b)};
            masked_word[b] = cur_word[b] && (wcol >= seg_left) && (wcol <= seg_right);
        end
    end

    assign o_done = (state_q == DONE);
    assign u_rd_512b_from_bram_o_rd_from_bram_trig = (state_q == RD_REQ);
    assign u_wr_512b_to_bram_o_wr_to_bram_trig     = (state_q == WR_REQ);
    assign u_rd_512b_from_bram_o_rd_from_bram_addr = {row_q, word_q};
    assign u_wr_512b_to_bram_o_wr_to_bram_addr     = {row_q, word_q};
    assign u_wr_512b_to_bram_o_wr_to_bram_data     = (state_q == WR_REQ) ? masked_word : '0;
endmodule

// File: tb/tb_boundary_search_ctrl.sv
// Bench for boundary_search_ctrl: BRAM models, directed table, corner sequences
// and randomized images checked against a row-level reference model.
module tb_boundary_search_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic        trig;
    logic        done;
    logic [3:0]  mg;
    logic [8:0]  start_row;
    logic [12:0] rd_addr, wr_addr;
    logic [31:0] rd_data, wr_data;
    logic        rd_trig, rd_done, wr_trig, wr_done;

    always #5 clk = ~clk;

    boundary_search_ctrl dut (
        .i_clk            (clk),
        .i_rstn           (rstn),
        .i_trig           (trig),
        .o_done           (done),
        .i_MAX_INTERVAL   (mg),
        .row_num_to_start (start_row),
        .u_rd_512b_from_bram_o_rd_from_bram_addr (rd_addr),
        .u_rd_512b_from_bram_i_rd_from_bram_data (rd_data),
        .u_rd_512b_from_bram_o_rd_from_bram_trig (rd_trig),
        .u_rd_512b_from_bram_i_rd_from_bram_done (rd_done),
        .u_wr_512b_to_bram_o_wr_to_bram_addr     (wr_addr),
        .u_wr_512b_to_bram_o_wr_to_bram_data     (wr_data),
        .u_wr_512b_to_bram_o_wr_to_bram_trig     (wr_trig),
        .u_wr_512b_to_bram_i_wr_to_bram_done     (wr_done)
    );

    logic [31:0] mem [0:8191];
    logic [12:0] rd_log[$], wr_alog[$], exp_rd[$], exp_wa[$];
    logic [31:0] wr_dlog[$], exp_wd[$];
    bit          var_lat = 1'b0;
    int          rd_ovl, wr_ovl, rd_cnt, wr_cnt;
    logic        rd_busy, wr_busy;
    logic [12:0] rd_a;
    int          checks = 0, errors = 0;

    // Read BRAM: one outstanding request, done after a fixed or random latency.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_busy <= 1'b0; rd_done <= 1'b0; rd_cnt <= 0; rd_data <= '0; rd_ovl <= 0; rd_a <= '0;
        end else begin
            rd_done <= 1'b0;
            if (rd_busy) begin
                if (rd_cnt <= 1) begin
                    rd_done <= 1'b1; rd_data <= mem[rd_a]; rd_busy <= 1'b0;
                end else rd_cnt <= rd_cnt - 1;
            end
            if (rd_trig) begin
                if (rd_busy || wr_busy) rd_ovl <= rd_ovl + 1;
                rd_busy <= 1'b1;
                rd_cnt  <= var_lat ? int'($urandom_range(5, 1)) : 2;
                rd_a    <= rd_addr;
                rd_log.push_back(rd_addr);
            end
        end
    end

    // Write BRAM: records every request; the image itself stays the original.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_busy <= 1'b0; wr_done <= 1'b0; wr_cnt <= 0; wr_ovl <= 0;
        end else begin
            wr_done <= 1'b0;
            if (wr_busy) begin
                if (wr_cnt <= 1) begin wr_done <= 1'b1; wr_busy <= 1'b0; end
                else wr_cnt <= wr_cnt - 1;
            end
            if (wr_trig) begin
                if (wr_busy || rd_busy || rd_trig) wr_ovl <= wr_ovl + 1;
                wr_busy <= 1'b1;
                wr_cnt  <= 2;
                wr_alog.push_back(wr_addr);
                wr_dlog.push_back(wr_data);
            end
        end
    end

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) mem[i] = '0;
    endtask

    task automatic set_px(int r, int c);
        if (c >= 0) mem[r*16 + c/32][c%32] = 1'b1;
    endtask

    // Reference: per row, first set pixel starts the segment; it extends over
    // set pixels while no more than mg consecutive zeros are seen.
    task automatic model(int start, int gmax);
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        for (int r = start; r < 512; r++) begin
            bit [511:0]  px;
            int          first, right, gap;
            logic [31:0] w;
            for (int k = 0; k < 16; k++) begin
                px[k*32 +: 32] = mem[r*16 + k];
                exp_rd.push_back(13'(r*16 + k));
            end
            first = -1;
            for (int c = 0; c < 512 && first < 0; c++) if (px[c]) first = c;
            if (first < 0) break;
            right = first; gap = 0;
            for (int c = first + 1; c < 512; c++) begin
                if (px[c]) begin right = c; gap = 0; end
                else begin gap++; if (gap > gmax) break; end
            end
            for (int k = 0; k < 16; k++) begin
                for (int b = 0; b < 32; b++) w[b] = px[k*32+b] && (k*32+b >= first) && (k*32+b <= right);
                exp_wa.push_back(13'(r*16 + k));
                exp_wd.push_back(w);
            end
        end
    endtask

    task automatic compare_model(string nm);
        int bad;
        check({nm, "_rd_cnt"}, rd_log.size(), exp_rd.size());
        check({nm, "_wr_cnt"}, wr_alog.size(), exp_wa.size());
        bad = 0;
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++) if (rd_log[i] !== exp_rd[i]) bad++;
        check({nm, "_rd_addr_bad"}, bad, 0);
        bad = 0;
        for (int i = 0; i < wr_alog.size() && i < exp_wa.size(); i++)
            if (wr_alog[i] !== exp_wa[i] || wr_dlog[i] !== exp_wd[i]) bad++;
        check({nm, "_wr_bad"}, bad, 0);
    endtask

    task automatic run_job(string nm, int start, int gmax);
        int n;
        rd_log.delete(); wr_alog.delete(); wr_dlog.delete();
        @(negedge clk);
        start_row = 9'(start); mg = 4'(gmax); trig = 1'b1;
        n = 0;
        while (!done && n < 20000) begin @(negedge clk); n++; end
        check({nm, "_done"}, done, 1'b1);
        trig = 1'b0;
        @(negedge clk);
        check({nm, "_done_drop"}, done, 1'b0);
    endtask

    typedef struct {
        int          start, gmax, c0, c1, c2, c3, n_wr, n_rd;
        logic [31:0] w0, w1;
    } vec_t;
    vec_t vecs[5];

    initial begin
        vecs[0] = '{20, 2, 5, 6, 9, 14, 16, 32, 32'h0000_0260, 32'h0};
        vecs[1] = '{40, 0, 31, 32, 34, -1, 16, 32, 32'h8000_0000, 32'h1};
        vecs[2] = '{60, 5, -1, -1, -1, -1, 0, 16, 32'h0, 32'h0};
        vecs[3] = '{80, 15, 0, 16, 33, -1, 16, 32, 32'h0001_0001, 32'h0};
        vecs[4] = '{100, 1, 3, -1, -1, -1, 16, 32, 32'h0000_0008, 32'h0};

        rstn = 1'b0; trig = 1'b0; mg = '0; start_row = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_done", done, 1'b0);
        check("rst_trigs", {rd_trig, wr_trig}, 2'b00);
        check("rst_addrs", {rd_addr, wr_addr, wr_data}, '0);
        rstn = 1'b1;

        foreach (vecs[v]) begin
            int bad;
            clear_mem();
            set_px(vecs[v].start, vecs[v].c0); set_px(vecs[v].start, vecs[v].c1);
            set_px(vecs[v].start, vecs[v].c2); set_px(vecs[v].start, vecs[v].c3);
            run_job($sformatf("vec%0d", v), vecs[v].start, vecs[v].gmax);
            check($sformatf("vec%0d_nrd", v), rd_log.size(), vecs[v].n_rd);
            check($sformatf("vec%0d_nwr", v), wr_dlog.size(), vecs[v].n_wr);
            if (vecs[v].n_wr > 0 && wr_dlog.size() >= 2) begin
                check($sformatf("vec%0d_w0", v), wr_dlog[0], vecs[v].w0);
                check($sformatf("vec%0d_w1", v), wr_dlog[1], vecs[v].w1);
                bad = 0;
                for (int k = 0; k < wr_alog.size(); k++) if (wr_alog[k] !== 13'(vecs[v].start*16 + k)) bad++;
                check($sformatf("vec%0d_wr_order", v), bad, 0);
            end
            model(vecs[v].start, vecs[v].gmax);
            compare_model($sformatf("vec%0d", v));
        end

        // Last row, full of ones; row 0 also loaded to catch wraparound.
        begin
            int bad;
            clear_mem();
            for (int k = 0; k < 16; k++) begin mem[511*16 + k] = '1; mem[k] = '1; end
            run_job("row511", 511, 3);
            check("row511_nwr", wr_dlog.size(), 16);
            bad = 0;
            foreach (wr_dlog[k]) if (wr_dlog[k] !== 32'hFFFF_FFFF || wr_alog[k][12:4] !== 9'd511) bad++;
            foreach (rd_log[k]) if (rd_log[k][12:4] !== 9'd511) bad++;
            check("row511_bad", bad, 0);
        end

        // Reset while a write is outstanding, then restart from a new row.
        begin
            int n;
            clear_mem();
            set_px(20, 5); set_px(20, 6);
            set_px(100, 3);
            @(negedge clk);
            start_row = 9'd20; mg = 4'd2; trig = 1'b1;
            n = 0;
            while (!wr_trig && n < 5000) begin @(negedge clk); n++; end
            check("rstmid_wr_seen", wr_trig, 1'b1);
            @(negedge clk);
            rstn = 1'b0; trig = 1'b0;
            #1;
            check("rstmid_outs", {done, rd_trig, wr_trig, rd_addr, wr_addr, wr_data}, '0);
            @(negedge clk);
            rstn = 1'b1;
            run_job("rstmid_restart", 100, 1);
            check("rstmid_first_rd", rd_log.size() > 0 ? rd_log[0] : 13'h1FFF, 13'(100*16));
            model(100, 1);
            compare_model("rstmid");
        end

        // Randomized images, alternating fixed and variable read latency.
        for (int it = 0; it < 10; it++) begin
            int s, g, nr;
            var_lat = it[0];
            clear_mem();
            s  = (it == 3) ? 510 : int'($urandom_range(508, 0));
            g  = int'($urandom_range(15, 0));
            nr = int'($urandom_range(3, 1));
            for (int r = s; r < s + nr && r < 512; r++)
                for (int k = 0; k < 16; k++) mem[r*16 + k] = $urandom & $urandom & $urandom;
            run_job($sformatf("rnd%0d", it), s, g);
            model(s, g);
            compare_model($sformatf("rnd%0d", it));
        end

        check("rd_overlap", rd_ovl, 0);
        check("wr_overlap", wr_ovl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
